// File: rtl/ram2_arbiter.sv
// ram2_arbiter: round-robin two-port arbiter/sequencer in front of a single-port RAM.
// Two requesters issue read/write transactions with a req/ack handshake; the block
// drives the RAM address, data-in and write strobe and returns read data per port.
// Optional feature macro: RAM2_ARB_INIT_CLEAR_EN (after reset, zero-fill the RAM
// through a CLEAR state before accepting requests).
module ram2_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_wr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);

  // Wait counter is 2 bits wide: RD_LAT is limited to 1..3.
  localparam logic [1:0] RD_LAT_C = 2'(RD_LAT);

`ifdef RAM2_ARB_INIT_CLEAR_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCESS = 3'd1,
    S_WAIT   = 3'd2,
    S_RESP   = 3'd3,
    S_CLEAR  = 3'd4
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_e;
`endif

  state_e              state_q, state_d;
  logic                last_gnt_q, last_gnt_d;
  logic                gnt_q, gnt_d;
  logic                we_q, we_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_din_q, ram_din_d;
  logic                ram_wr_q, ram_wr_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                busy_q, busy_d;
  logic                sel1_s;

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef RAM2_ARB_INIT_CLEAR_EN
      state_q  <= S_CLEAR;
      ram_wr_q <= 1'b1;
      busy_q   <= 1'b1;
`else
      state_q  <= S_IDLE;
      ram_wr_q <= 1'b0;
      busy_q   <= 1'b0;
`endif
      last_gnt_q <= 1'b1;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      cnt_q      <= 2'd0;
      ram_addr_q <= {ADDR_W{1'b0}};
      ram_din_q  <= {DATA_W{1'b0}};
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rdata0_q   <= {DATA_W{1'b0}};
      rdata1_q   <= {DATA_W{1'b0}};
    end else begin
      state_q    <= state_d;
      ram_wr_q   <= ram_wr_d;
      busy_q     <= busy_d;
      last_gnt_q <= last_gnt_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  // Next-state and next-output logic; RAM-side values are computed one cycle
  // ahead so that they appear registered in the cycle they apply to.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    cnt_d      = cnt_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ram_wr_d   = 1'b0;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    sel1_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // On a tie the port opposite the previous grant wins.
          if (req0 && req1) begin
            sel1_s = ~last_gnt_q;
          end else begin
            sel1_s = req1;
          end
          gnt_d      = sel1_s;
          last_gnt_d = sel1_s;
          we_d       = sel1_s ? we1 : we0;
          ram_addr_d = sel1_s ? addr1 : addr0;
          ram_din_d  = sel1_s ? wdata1 : wdata0;
          ram_wr_d   = sel1_s ? we1 : we0;
          state_d    = S_ACCESS;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (we_q) begin
          // Write commits at the edge ending ACCESS; acknowledge next cycle.
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          state_d = S_RESP;
        end else begin
          cnt_d   = RD_LAT_C;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          if (gnt_q) begin
            rdata1_d = ram_dout;
          end else begin
            rdata0_d = ram_dout;
          end
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
`ifdef RAM2_ARB_INIT_CLEAR_EN
      S_CLEAR: begin
        ram_din_d = {DATA_W{1'b0}};
        if (ram_addr_q == {ADDR_W{1'b1}}) begin
          ram_wr_d = 1'b0;
          state_d  = S_IDLE;
        end else begin
          ram_wr_d   = 1'b1;
          ram_addr_d = ram_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          state_d    = S_CLEAR;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign ram_wr   = ram_wr_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_ram2_arbiter.sv
// Directed self-checking bench for ram2_arbiter with a behavioural 16x4 RAM
// (registered read, one cycle of latency).
`timescale 1ns/1ps
module tb_ram2_arbiter;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 4;
  localparam int RD_LAT = 1;
`ifdef RAM2_ARB_INIT_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
  logic              ack0, ack1, ram_wr, busy;
  logic [DATA_W-1:0] rdata0, rdata1, ram_din;
  logic [DATA_W-1:0] ram_dout = '0;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] mem [0:15];

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt = 0;
  logic [ADDR_W-1:0] last_wa;
  logic [DATA_W-1:0] last_wd;

  ram2_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_wr(ram_wr), .ram_dout(ram_dout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // RAM model: write on rising edge while ram_wr, registered read data.
  always @(posedge clk) begin
    if (ram_wr === 1'b1) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  // Count write-strobe cycles and remember the last written address/data.
  always @(negedge clk) begin
    if (ram_wr === 1'b1) begin
      wr_cnt  = wr_cnt + 1;
      last_wa = ram_addr;
      last_wd = ram_din;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One complete transaction from an idle arbiter; lat = ack cycle - request cycle.
  task automatic txn(input int p, input logic w, input logic [3:0] a, input logic [3:0] d,
                     output int lat);
    int   cyc;
    logic got;
    @(posedge clk); #1;
    if (p == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 50) begin
      @(negedge clk);
      cyc++;
      got = (p == 0) ? ack0 : ack1;
    end
    @(posedge clk); #1;
    req0 = 1'b0;
    req1 = 1'b0;
    lat = got ? cyc - 1 : -1;
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy !== 1'b0 && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("wait_idle", {31'd0, busy}, 32'd0);
  endtask

  int lat;
  int n_ack, both, ack1_seen;
  int order [0:5];

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 4'h0;

    // Reset with both requests high.
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
    we0 = 1'b0; addr0 = 4'd7; we1 = 1'b0; addr1 = 4'd2;
    @(negedge clk);
    check("ack_in_reset", {30'd0, ack0, ack1}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ack", {30'd0, ack0, ack1}, 32'd0);
    check("rst_rdata", {24'd0, rdata0, rdata1}, 32'd0);
    check("rst_ram_addr", {28'd0, ram_addr}, 32'd0);
    check("rst_ram_din", {28'd0, ram_din}, 32'd0);
    check("rst_ram_wr", {31'd0, ram_wr}, {31'd0, CLR});
    check("rst_busy", {31'd0, busy}, {31'd0, CLR});

`ifdef RAM2_ARB_INIT_CLEAR_EN
    // Clear sweep: 16 cycles of zero writes while requests are held off.
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      if (ram_wr !== 1'b1 || ram_din !== 4'h0 || ram_addr !== 4'(i) ||
          busy !== 1'b1 || ack0 !== 1'b0)
        check("clear_step", {ram_wr, busy, ack0, ram_din, ram_addr}, {3'b110, 4'h0, 4'(i)});
    end
    n_checks++;
`endif

    // Fairness: both ports keep requesting reads.
    n_ack = 0;
    both  = 0;
    for (int c = 0; c < 200 && n_ack < 6; c++) begin
      @(negedge clk);
      if (ack0 && ack1) both++;
      if (ack0) begin
        if (n_ack == 0) check("first_rdata0", {28'd0, rdata0}, 32'd0);
        order[n_ack] = 0;
        n_ack++;
      end else if (ack1) begin
        order[n_ack] = 1;
        n_ack++;
      end
    end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    check("fair_n_ack", n_ack, 6);
    check("ack_overlap", both, 0);
    for (int k = 0; k < 6; k++) check($sformatf("grant_order[%0d]", k), order[k], k % 2);

    // Single write then read back on the other port.
    wr_cnt = 0;
    txn(0, 1'b1, 4'd5, 4'hA, lat);
    check("wr_latency", lat, 2);
    check("wr_pulses", wr_cnt, 1);
    check("wr_addr", {28'd0, last_wa}, 32'd5);
    check("wr_data", {28'd0, last_wd}, 32'hA);
    txn(1, 1'b0, 4'd5, 4'h0, lat);
    check("rd_latency", lat, 2 + RD_LAT);
    check("rd_rdata1", {28'd0, rdata1}, 32'hA);
    check("rd_no_wr", wr_cnt, 1);

    // Sweep: write i to address i, read all back on port 1.
    wr_cnt = 0;
    for (int i = 0; i < 16; i++) txn(0, 1'b1, 4'(i), 4'(i), lat);
    check("sweep_wr_pulses", wr_cnt, 16);
    for (int i = 0; i < 16; i++) begin
      txn(1, 1'b0, 4'(i), 4'h0, lat);
      check($sformatf("sweep_rd[%0d]", i), {28'd0, rdata1}, i);
    end

    // Writes leave rdata untouched.
    txn(0, 1'b0, 4'd9, 4'h0, lat);
    check("rd9_rdata0", {28'd0, rdata0}, 32'd9);
    txn(0, 1'b1, 4'd3, 4'h6, lat);
    check("rdata0_after_wr", {28'd0, rdata0}, 32'd9);

    // Reset in the WAIT cycle of a port 1 read.
    @(posedge clk); #1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'd12;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrd_busy_before", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    rst  = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    check("midrd_busy_after", {31'd0, busy}, {31'd0, CLR});
    check("midrd_rdata1", {28'd0, rdata1}, 32'd0);
    ack1_seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (ack1) ack1_seen++;
      @(negedge clk);
    end
    check("midrd_no_ack", ack1_seen, 0);
    wait_idle();
    txn(0, 1'b0, 4'd3, 4'h0, lat);
    check("post_rst_rd3", {28'd0, rdata0}, CLR ? 32'd0 : 32'd6);
    check("post_rst_lat", lat, 2 + RD_LAT);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram2_arbiter.md
Name: ram2_arbiter

Overview:
Two-port arbiter and sequencer for the single-port 16x4 RAM2 block. Two independent requesters issue read/write transactions with a req/ack handshake. The block grants them round-robin, drives the RAM address, data-in and write strobe, waits out the RAM read latency, and returns read data per port. It sits between the requesters and the RAM instance and is the only driver of the RAM port.

Parameters:
- ADDR_W, 4, RAM address width (depth = 2**ADDR_W)
- DATA_W, 4, RAM data width
- RD_LAT, 1, cycles from ram_addr stable to ram_dout valid; legal range 1..3

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- req0  input  1  port 0 transaction request; held until ack0
- we0  input  1  port 0: 1 = write, 0 = read
- addr0  input  ADDR_W  port 0 address
- wdata0  input  DATA_W  port 0 write data
- ack0  output  1  port 0 completion, one-cycle pulse
- rdata0  output  DATA_W  port 0 read data, valid from ack0 onward
- req1, we1, addr1, wdata1, ack1, rdata1  same as port 0, for port 1
- ram_addr  output  ADDR_W  to RAM addr
- ram_din  output  DATA_W  to RAM dataIN
- ram_wr  output  1  to RAM WR; RAM writes on a rising edge while high
- ram_dout  input  DATA_W  from RAM dataOUT
- busy  output  1  high whenever state != IDLE

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. No asynchronous reset anywhere.
- Reset values:
  - ack0/1 = 0, rdata0/1 = 0
  - ram_addr = 0, ram_din = 0, ram_wr = 0
  - busy = 0, state = IDLE
  - last_gnt = 1, so port 0 wins the first tie.
- FSM states: IDLE, ACCESS, WAIT, RESP. All outputs are registered.
- IDLE:
  - Requester inputs are sampled only in IDLE.
  - If exactly one req is high, grant it.
  - If both are high, grant the port opposite last_gnt, then update last_gnt.
  - Latch we, addr and wdata of the granted port into internal registers and go to ACCESS.
  - With no req, stay in IDLE.
  - ram_wr = 0. ram_addr and ram_din hold their last values.
- ACCESS (exactly 1 cycle):
  - ram_addr = latched addr, ram_din = latched wdata, ram_wr = latched we.
  - Write: the write commits at the edge ending ACCESS; next state is RESP.
  - Read: load the wait counter with RD_LAT; next state is WAIT.
- WAIT:
  - ram_addr is held and ram_wr = 0.
  - The counter decrements each cycle.
  - In the last WAIT cycle (counter = 1), ram_dout is captured into rdataX of the granted port; next state is RESP.
- RESP (1 cycle):
  - ackX = 1 for the granted port only; next state is IDLE.
  - rdataX holds until that port's next read completes. Writes never modify rdataX.
- Latency, with the request seen in IDLE on cycle N:
  - Write: ACCESS at N+1, ack at N+2.
  - Read: ack at N+2+RD_LAT.
  - Minimum turnaround between grants: 3 cycles for a write, 3+RD_LAT for a read.
- Handshake:
  - The requester holds req, we, addr and wdata stable until ack. Changes after the grant cycle are ignored.
  - If req is still high in the IDLE cycle after ack, it is treated as a new request.
- Fairness: if both ports hold req continuously, grants strictly alternate. A lone requester is served back-to-back with no penalty.
- A req on the non-granted port during ACCESS, WAIT or RESP waits. It is arbitrated in the next IDLE.
- ram_wr is high for exactly one cycle per write transaction and never during a read.
- Reset mid-transaction:
  - The transaction is aborted at the reset edge and no ack is issued.
  - ram_wr drops to 0 and state returns to IDLE.
  - RAM contents already written are not touched.
- Address/data arithmetic: none. Fields pass through at full width with no wrap logic.

Optional Feature:
- Macro: RAM2_ARB_INIT_CLEAR_EN.
- Defined:
  - Reset enters state CLEAR instead of IDLE. busy = 1.
  - For 2**ADDR_W consecutive cycles, ram_wr = 1, ram_din = 0 and ram_addr counts 0..2**ADDR_W-1.
  - Then go to IDLE.
  - Requests arriving during CLEAR are held off (no ack) and arbitrated in the first IDLE cycle.
  - rst during CLEAR restarts the clear from address 0.
- Undefined: no CLEAR state. Reset goes directly to IDLE and RAM contents are untouched.

Test Plan:
- Reset: hold rst high 2 clk edges with req0/req1 high -> ack0/1, rdata0/1, ram_wr, ram_addr, ram_din and busy are all 0. No ack is issued during reset.
- Single write then read: port 0 writes addr 5, data 0xA -> ram_wr high exactly 1 cycle with ram_addr = 5 and ram_din = 0xA, and ack0 two cycles after the request is sampled. Port 1 then reads addr 5 -> rdata1 = 0xA, with ack1 at 2+RD_LAT cycles.
- Tie and fairness: both ports raise a read immediately after reset and keep re-requesting after each ack -> grant order is 0,1,0,1,0,1. ack0 and ack1 are never high in the same cycle.
- Sweep: port 0 writes addr i with data i for i = 0..15, then port 1 reads addr 0..15 -> rdata1 = i for each read. ram_wr pulses exactly 16 times.
- Reset mid-read: assert rst for 1 cycle while in WAIT -> no ack for that transaction, and busy = 0 after the reset edge. A subsequent port 0 read of addr 3 (previously written 0x6) returns 0x6.
- RAM2_ARB_INIT_CLEAR_EN defined: after reset, busy stays high for 16 cycles with ram_wr = 1, ram_din = 0 and ram_addr stepping 0..15. A req0 read of addr 7 raised during the clear is acked only after the clear finishes and returns 0.
